// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA parameter controller: FSM encoding, error codes
// and the default wait budget for the external arithmetic units.
package rsa_pkg;

  localparam int TIMEOUT_CYC_DEFAULT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_LCM_RST  = 3'd2,
    ST_LCM_WAIT = 3'd3,
    ST_GCD_RST  = 3'd4,
    ST_GCD_WAIT = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_OPERAND = 2'd1;
  localparam logic [1:0] ERR_OVF     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Primes and the public exponent must all be at least 2 to be meaningful.
  function automatic logic operand_invalid(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] c);
    return (a < 32'd2) || (b < 32'd2) || (c < 32'd2);
  endfunction

endpackage

// File: rtl/unit_launch.sv
// Pulse-and-wait handshake for one external arithmetic unit: holds the unit in
// reset outside its wait window, masks the first wait cycle, and bounds the wait.
module unit_launch
  import rsa_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic ready_n,
  output logic unit_rst_n,
  output logic ready_hit,
  output logic timed_out
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST_CYC = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_reg;
  logic          first_cycle;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (waiting) begin
      cnt_reg <= cnt_reg + 1'b1;
    end else begin
      cnt_reg <= '0;
    end
  end

  // The unit is still coming out of reset in the first wait cycle, so its
  // ready flag is not trusted there.
  assign first_cycle = (cnt_reg == '0);
  assign unit_rst_n  = waiting;
  assign ready_hit   = waiting && !first_cycle && !ready_n;
  // A ready arriving on the last allowed cycle beats the timeout.
  assign timed_out   = waiting && (cnt_reg == LAST_CYC) && !ready_hit;

endmodule

// File: rtl/rsa_param_ctrl.sv
// Sequences an external LCM unit then GCD unit to derive lambda = lcm(p-1, q-1)
// and check that e is coprime to it.
module rsa_param_ctrl
  import rsa_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] p,
  input  logic [31:0] q,
  input  logic [31:0] e,
  output logic        busy,
  output logic        done,
  output logic        key_ok,
  output logic [1:0]  err_code,
  output logic [31:0] lambda,
  output logic [31:0] lcm_a,
  output logic [31:0] lcm_b,
  output logic        lcm_rst_n,
  input  logic [63:0] lcm_result,
  input  logic        lcm_ready_n,
  output logic [31:0] gcd_a,
  output logic [31:0] gcd_b,
  output logic        gcd_rst_n,
  input  logic [31:0] gcd_result,
  input  logic        gcd_ready_n
);

  state_t      state_reg, state_next;
  logic [31:0] p_reg, q_reg, e_reg;
  logic [31:0] lcm_a_reg, lcm_b_reg, gcd_a_reg, gcd_b_reg;
  logic [31:0] lambda_reg;
  logic [1:0]  err_reg;
  logic        key_reg;

  logic lcm_wait, lcm_hit, lcm_to;
  logic gcd_wait, gcd_hit, gcd_to;
  logic bad_operand, lcm_ovf;

  assign lcm_wait    = (state_reg == ST_LCM_WAIT);
  assign gcd_wait    = (state_reg == ST_GCD_WAIT);
  assign bad_operand = operand_invalid(p_reg, q_reg, e_reg);
  assign lcm_ovf     = (lcm_result[63:32] != 32'd0);

  unit_launch #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_lcm_launch (
    .clk        (clk),
    .rst_n      (rst_n),
    .waiting    (lcm_wait),
    .ready_n    (lcm_ready_n),
    .unit_rst_n (lcm_rst_n),
    .ready_hit  (lcm_hit),
    .timed_out  (lcm_to)
  );

  unit_launch #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gcd_launch (
    .clk        (clk),
    .rst_n      (rst_n),
    .waiting    (gcd_wait),
    .ready_n    (gcd_ready_n),
    .unit_rst_n (gcd_rst_n),
    .ready_hit  (gcd_hit),
    .timed_out  (gcd_to)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        state_next = bad_operand ? ST_DONE : ST_LCM_RST;
      end
      ST_LCM_RST: begin
        state_next = ST_LCM_WAIT;
      end
      ST_LCM_WAIT: begin
        if (lcm_hit) begin
          state_next = lcm_ovf ? ST_DONE : ST_GCD_RST;
        end else if (lcm_to) begin
          state_next = ST_DONE;
        end
      end
      ST_GCD_RST: begin
        state_next = ST_GCD_WAIT;
      end
      ST_GCD_WAIT: begin
        if (gcd_hit || gcd_to) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Result registers are cleared on an accepted start and otherwise only
  // written at the decision point of each state, so they hold after done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_reg      <= '0;
      q_reg      <= '0;
      e_reg      <= '0;
      lcm_a_reg  <= '0;
      lcm_b_reg  <= '0;
      gcd_a_reg  <= '0;
      gcd_b_reg  <= '0;
      lambda_reg <= '0;
      err_reg    <= ERR_OK;
      key_reg    <= 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (start) begin
            p_reg      <= p;
            q_reg      <= q;
            e_reg      <= e;
            lcm_a_reg  <= p - 32'd1;
            lcm_b_reg  <= q - 32'd1;
            gcd_a_reg  <= '0;
            gcd_b_reg  <= '0;
            lambda_reg <= '0;
            err_reg    <= ERR_OK;
            key_reg    <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (bad_operand) err_reg <= ERR_OPERAND;
        end
        ST_LCM_WAIT: begin
          if (lcm_hit) begin
            lambda_reg <= lcm_result[31:0];
            gcd_a_reg  <= e_reg;
            gcd_b_reg  <= lcm_result[31:0];
            if (lcm_ovf) err_reg <= ERR_OVF;
          end else if (lcm_to) begin
            err_reg <= ERR_TIMEOUT;
          end
        end
        ST_GCD_WAIT: begin
          if (gcd_hit) begin
            key_reg <= (gcd_result == 32'd1);
          end else if (gcd_to) begin
            err_reg <= ERR_TIMEOUT;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy     = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  assign done     = (state_reg == ST_DONE);
  assign key_ok   = key_reg;
  assign err_code = err_reg;
  assign lambda   = lambda_reg;
  assign lcm_a    = lcm_a_reg;
  assign lcm_b    = lcm_b_reg;
  assign gcd_a    = gcd_a_reg;
  assign gcd_b    = gcd_b_reg;

endmodule

// File: tb/tb_rsa_param_ctrl.sv
// Randomised bench for rsa_param_ctrl with behavioural LCM/GCD unit models and an
// arithmetic reference for lambda, key_ok, err_code and done timing.
module tb_rsa_param_ctrl;

  localparam int T = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] p = '0, q = '0, e = '0;
  logic        busy, done, key_ok;
  logic [1:0]  err_code;
  logic [31:0] lambda;
  logic [31:0] lcm_a, lcm_b, gcd_a, gcd_b;
  logic        lcm_rst_n, gcd_rst_n;
  logic [63:0] lcm_result = '0;
  logic        lcm_ready_n = 1'b1;
  logic [31:0] gcd_result = '0;
  logic        gcd_ready_n = 1'b1;

  int total = 0;
  int bad = 0;

  bit lcm_stuck = 1'b0;
  int lcm_lat = 1;
  int gcd_lat = 1;
  int lcm_cnt = 0;
  int gcd_cnt = 0;

  always #5 clk = ~clk;

  rsa_param_ctrl #(.TIMEOUT_CYC(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .p           (p),
    .q           (q),
    .e           (e),
    .busy        (busy),
    .done        (done),
    .key_ok      (key_ok),
    .err_code    (err_code),
    .lambda      (lambda),
    .lcm_a       (lcm_a),
    .lcm_b       (lcm_b),
    .lcm_rst_n   (lcm_rst_n),
    .lcm_result  (lcm_result),
    .lcm_ready_n (lcm_ready_n),
    .gcd_a       (gcd_a),
    .gcd_b       (gcd_b),
    .gcd_rst_n   (gcd_rst_n),
    .gcd_result  (gcd_result),
    .gcd_ready_n (gcd_ready_n)
  );

  function automatic logic [63:0] ref_gcd(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic logic [63:0] ref_lcm(input logic [63:0] a, input logic [63:0] b);
    if (a == 0 || b == 0) return 64'd0;
    return (a / ref_gcd(a, b)) * b;
  endfunction

  // External unit models: count cycles out of reset, then raise ready (low).
  always @(posedge clk) begin
    if (!lcm_rst_n) begin
      lcm_cnt     <= 0;
      lcm_ready_n <= 1'b1;
    end else if (!lcm_stuck) begin
      lcm_cnt <= lcm_cnt + 1;
      if (lcm_cnt + 1 == lcm_lat) begin
        lcm_ready_n <= 1'b0;
        lcm_result  <= ref_lcm({32'd0, lcm_a}, {32'd0, lcm_b});
      end
    end
  end

  always @(posedge clk) begin
    logic [63:0] g;
    g = ref_gcd({32'd0, gcd_a}, {32'd0, gcd_b});
    if (!gcd_rst_n) begin
      gcd_cnt     <= 0;
      gcd_ready_n <= 1'b1;
    end else begin
      gcd_cnt <= gcd_cnt + 1;
      if (gcd_cnt + 1 == gcd_lat) begin
        gcd_ready_n <= 1'b0;
        gcd_result  <= g[31:0];
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input logic [31:0] tp, input logic [31:0] tq, input logic [31:0] te,
                         input bit stuck, input int llat, input int glat, input bit second);
    logic [63:0] l;
    logic [1:0]  x_err;
    bit          x_key, lhi, ghi, is_bad;
    logic [31:0] x_lam;
    int          x_done, first_done, ndone;
    is_bad = (tp < 2) || (tq < 2) || (te < 2);
    x_key = 1'b0;
    x_lam = '0;
    x_err = 2'd0;
    l = '0;
    if (is_bad) begin
      x_err = 2'd1;
      x_done = 2;
    end else if (stuck || llat >= T) begin
      x_err = 2'd3;
      x_done = 3 + T;
    end else begin
      l = ref_lcm({32'd0, tp - 32'd1}, {32'd0, tq - 32'd1});
      x_lam = l[31:0];
      if (l[63:32] != 0) begin
        x_err = 2'd2;
        x_done = 4 + llat;
      end else if (glat >= T) begin
        x_err = 2'd3;
        x_done = 5 + llat + T;
      end else begin
        x_key = (ref_gcd({32'd0, te}, l) == 64'd1);
        x_done = 6 + llat + glat;
      end
    end
    lcm_stuck = stuck;
    lcm_lat = llat;
    gcd_lat = glat;
    @(negedge clk);
    p = tp;
    q = tq;
    e = te;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("busy_after_start", busy, 1);
    first_done = 0;
    ndone = 0;
    lhi = 1'b0;
    ghi = 1'b0;
    for (int cyc = 1; cyc <= x_done + 4; cyc++) begin
      if (cyc > 1) @(negedge clk);
      start = second && (cyc == 5);
      lhi |= lcm_rst_n;
      ghi |= gcd_rst_n;
      if (done) begin
        ndone++;
        if (first_done == 0) begin
          first_done = cyc;
          check_val("busy_at_done", busy, 0);
          check_val("key_at_done", key_ok, x_key);
        end
      end
    end
    start = 1'b0;
    check_val("done_cycle", first_done, x_done);
    check_val("done_count", ndone, 1);
    check_val("key_ok", key_ok, x_key);
    check_val("err_code", err_code, x_err);
    check_val("lambda", lambda, x_lam);
    check_val("busy_idle", busy, 0);
    if (is_bad) check_val("lcm_rst_n_hi", lhi, 0);
    if (x_err == 2'd2) check_val("gcd_rst_n_hi", ghi, 0);
    $display("txn p=%0d q=%0d e=%0d llat=%0d glat=%0d -> lambda=%0d key_ok=%0d err=%0d done@%0d",
             tp, tq, te, llat, glat, lambda, key_ok, err_code, first_done);
  endtask

  initial begin
    logic [31:0] rp, rq, re;
    bit seen;
    int nd;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_key", key_ok, 0);
    check_val("rst_err", err_code, 0);
    check_val("rst_lambda", lambda, 0);
    check_val("rst_lcm_rst_n", lcm_rst_n, 0);
    check_val("rst_gcd_rst_n", gcd_rst_n, 0);
    check_val("rst_ops", {lcm_a | lcm_b, gcd_a | gcd_b}, 0);
    rst_n = 1'b1;

    run_txn(32'd61, 32'd53, 32'd17, 1'b0, 3, 2, 1'b0);
    run_txn(32'd61, 32'd53, 32'd15, 1'b0, 1, 5, 1'b0);
    run_txn(32'd1, 32'd53, 32'd17, 1'b0, 2, 2, 1'b0);
    run_txn(32'd4294967291, 32'd4294967281, 32'd65537, 1'b0, 4, 2, 1'b0);
    run_txn(32'd61, 32'd53, 32'd17, 1'b1, 1, 1, 1'b1);
    run_txn(32'd61, 32'd53, 32'd17, 1'b0, T - 1, 2, 1'b0);
    run_txn(32'd61, 32'd53, 32'd17, 1'b0, T, 2, 1'b0);
    run_txn(32'd61, 32'd53, 32'd17, 1'b0, 2, T, 1'b0);

    // Reset in the middle of the GCD wait must abandon the request silently.
    lcm_stuck = 1'b0;
    lcm_lat = 3;
    gcd_lat = 40;
    @(negedge clk);
    p = 32'd61;
    q = 32'd53;
    e = 32'd17;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (gcd_rst_n) seen = 1'b1;
    end
    check_val("reach_gcd_wait", seen, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_val("midrst_busy", busy, 0);
    check_val("midrst_gcd_rst_n", gcd_rst_n, 0);
    check_val("midrst_done", done, 0);
    nd = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check_val("midrst_no_done", nd, 0);
    run_txn(32'd61, 32'd53, 32'd17, 1'b0, 2, 3, 1'b0);

    for (int n = 0; n < 14; n++) begin
      rp = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 1)) : 32'($urandom_range(2, 70000));
      rq = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 1)) : 32'($urandom_range(2, 70000));
      re = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 1)) : 32'($urandom_range(2, 1000));
      run_txn(rp, rq, re, 1'b0, int'($urandom_range(1, 20)), int'($urandom_range(1, 20)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rsa_param_ctrl.md
RSA_PARAM_CTRL -- requirements
Module: rsa_param_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, 1024, maximum cycles to wait for one arithmetic unit to report ready.
REQ-002 SHALL have ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- p, q, e  in  32 each  primes and public exponent.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- key_ok  out  1  e coprime to lambda; valid when done is high.
- err_code  out  2  0 ok, 1 bad operand, 2 lambda overflow, 3 timeout.
- lambda  out  32  lcm(p-1, q-1).
- lcm_a, lcm_b  out  32 each  LCM unit operands.
- lcm_rst_n  out  1  LCM unit reset/start.
- lcm_result  in  64  LCM unit result.
- lcm_ready_n  in  1  LCM unit done, active-low.
- gcd_a, gcd_b  out  32 each  GCD unit operands.
- gcd_rst_n  out  1  GCD unit reset/start.
- gcd_result  in  32  GCD unit result.
- gcd_ready_n  in  1  GCD unit done, active-low.

Function
REQ-003 SHALL sequence the states IDLE -> CHECK -> LCM_RST -> LCM_WAIT -> GCD_RST -> GCD_WAIT -> DONE -> IDLE.
REQ-004 SHALL, in IDLE with start=1, latch p, q and e, enter CHECK next cycle and raise busy; start while busy SHALL be ignored.
REQ-005 SHALL, in CHECK, go to DONE with err_code=1 and key_ok=0 if p<2, q<2 or e<2; otherwise go to LCM_RST.
REQ-006 SHALL hold lcm_a=p-1 and lcm_b=q-1 from CHECK until LCM_WAIT exits, with lcm_rst_n=0 for exactly the one LCM_RST cycle.
REQ-007 SHALL, in LCM_WAIT, drive lcm_rst_n=1 and ignore lcm_ready_n in the first LCM_WAIT cycle.
REQ-008 SHALL, on lcm_ready_n=0 in LCM_WAIT:
- capture lcm_result[31:0] into lambda;
- if lcm_result[63:32]!=0, go to DONE with err_code=2 and key_ok=0;
- otherwise go to GCD_RST.
REQ-009 SHALL run the GCD unit with the same pulse-and-wait protocol, with gcd_a=e and gcd_b=lambda, entering DONE on gcd_ready_n=0.
REQ-010 SHALL set key_ok=1 only when gcd_result==1 and err_code=0; gcd_result!=1 SHALL give key_ok=0 with err_code=0.
REQ-011 SHALL count cycles in each WAIT state and go to DONE with err_code=3 and key_ok=0 when the count reaches TIMEOUT_CYC.
REQ-012 SHALL, when ready_n is low and the count reaches TIMEOUT_CYC in the same cycle, give priority to ready_n.
REQ-013 SHALL hold lcm_rst_n=0 and gcd_rst_n=0 in every state except the unit's own WAIT state.
REQ-014 SHALL, in DONE, pulse done=1 for one cycle, drop busy in the same cycle and return to IDLE.
REQ-015 SHALL hold key_ok, err_code and lambda until the next accepted start, which SHALL clear them.
REQ-016 SHALL complete a bad-operand request with done exactly 2 cycles after start.

Reset
REQ-017 SHALL, while rst_n=0 at a clock edge, enter IDLE and clear all outputs:
- busy=0, done=0, key_ok=0, err_code=0, lambda=0;
- lcm_rst_n=0, gcd_rst_n=0;
- all operand outputs=0, timeout counter=0.
REQ-018 SHALL, on reset mid-operation, abandon the operation with no done pulse, and the units SHALL be held in reset from the next cycle.

Structure
REQ-019 SHALL take the state encoding, the err_code constants (ERR_OK, ERR_OPERAND, ERR_OVF, ERR_TIMEOUT) and the TIMEOUT_CYC default from shared package rsa_pkg.
REQ-020 SHALL place the pulse/wait/timeout logic in one sub-module, unit_launch, instantiated once per unit.
REQ-021 SHALL NOT instantiate the GCD or LCM units; the parent level connects them.

Verification
REQ-022 p=61, q=53, e=17 -> lambda=780, key_ok=1, err_code=0, exactly one done pulse.
REQ-023 p=61, q=53, e=15 -> lambda=780, key_ok=0, err_code=0.
REQ-024 p=1, q=53, e=17 -> done 2 cycles after start, err_code=1, lcm_rst_n never high.
REQ-025 p=4294967291, q=4294967281, e=65537 -> err_code=2, key_ok=0, gcd_rst_n never high.
REQ-026 LCM model with lcm_ready_n stuck at 1 -> done after TIMEOUT_CYC wait cycles with err_code=3; a second start during busy is ignored.
REQ-027 rst_n=0 for 1 cycle during GCD_WAIT -> busy=0 and gcd_rst_n=0 next cycle, no done pulse; a following start with p=61, q=53, e=17 completes correctly.
